pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage ARM core.
- Drives the enable and clear of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three events: RAW data hazards in ID, taken-branch flushes from EXE, and multi-cycle SRAM accesses in MEM.
- Runs a memory-wait state machine with a watchdog timeout and keeps saturating stall/flush statistics counters.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: FSM encoding, register index width,
// and the per-stage register control bundle with its canonical settings.
package pipe_pkg;

    localparam int REG_W           = 4;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_en;
        logic if_clr;
        logic id_en;
        logic id_clr;
        logic exe_en;
        logic mem_en;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = '0;
    localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, if_en: 1'b1, if_clr: 1'b0, id_en: 1'b1,
                                      id_clr: 1'b0, exe_en: 1'b1, mem_en: 1'b1};
    localparam ctrl_t CTRL_FLUSH  = '{pc_en: 1'b1, if_en: 1'b1, if_clr: 1'b1, id_en: 1'b1,
                                      id_clr: 1'b1, exe_en: 1'b1, mem_en: 1'b1};
    // Hold PC and IF/ID, inject a bubble into ID/EX, let older stages drain.
    localparam ctrl_t CTRL_BUBBLE = '{pc_en: 1'b0, if_en: 1'b0, if_clr: 1'b0, id_en: 1'b1,
                                      id_clr: 1'b1, exe_en: 1'b1, mem_en: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard detection for the instruction in ID, purely combinational (0 cycles).
// PIPE_FWD_EN defined: only load-use against EXE stalls; otherwise any EXE/MEM match stalls.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             hazard
);

    logic exe_h;
    logic mem_h;

    always_comb begin
        exe_h = exe_wb_en && ((id_use_src1 && (id_src1 == exe_dest)) ||
                              (id_two_src  && (id_src2 == exe_dest)));
        mem_h = mem_wb_en && ((id_use_src1 && (id_src1 == mem_dest)) ||
                              (id_two_src  && (id_src2 == mem_dest)));
    end

`ifdef PIPE_FWD_EN
    // Forwarding covers everything except a load result still in flight.
    assign hazard = exe_h && exe_mem_r_en;
    logic unused_mem_h;
    assign unused_mem_h = mem_h;
`else
    assign hazard = exe_h || mem_h;
    logic unused_load;
    assign unused_load = exe_mem_r_en;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: Mealy stage enables/clears from hazards, branch flushes and SRAM waits.
// Watchdog traps to ERROR after MEM_TIMEOUT frozen cycles; saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_reg_en,
    output logic             if_reg_clr,
    output logic             id_reg_en,
    output logic             id_reg_clr,
    output logic             exe_reg_en,
    output logic             mem_reg_en,
    output logic             hazard,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    ctrl_t             ctrl;
    logic              issue;
    logic              stall_inc;
    logic              flush_inc;

    hazard_detect u_hazard_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use_src1  (id_use_src1),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = CTRL_FREEZE;
        issue      = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                    stall_inc  = 1'b1;
                end else begin
                    issue = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    issue      = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    stall_inc  = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ERROR;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // A branch held in EXE during a freeze is flushed on the release cycle.
        if (issue) begin
            if (branch_taken) begin
                ctrl      = CTRL_FLUSH;
                flush_inc = 1'b1;
            end else if (hazard) begin
                ctrl      = CTRL_BUBBLE;
                stall_inc = 1'b1;
            end else begin
                ctrl = CTRL_RUN;
            end
        end

        if (rst) begin
            ctrl = CTRL_FREEZE;
        end

        stall_cnt_d = (stall_inc && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_inc && flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign if_reg_en  = ctrl.if_en;
    assign if_reg_clr = ctrl.if_clr;
    assign id_reg_en  = ctrl.id_en;
    assign id_reg_clr = ctrl.id_clr;
    assign exe_reg_en = ctrl.exe_en;
    assign mem_reg_en = ctrl.mem_en;
    assign mem_err    = (state_q == ERROR);
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then randomized traffic,
// each cycle's expected response comes from a rule-level model and is checked by a monitor.
module tb_pipe_hazard_ctrl;

    localparam int TO   = 8;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [3:0]    id_src1, id_src2, exe_dest, mem_dest;
    logic          id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic          branch_taken, mem_req, mem_ready;
    logic          pc_en, if_reg_en, if_reg_clr, id_reg_en, id_reg_clr, exe_reg_en, mem_reg_en;
    logic          hazard, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_reg_en(if_reg_en), .if_reg_clr(if_reg_clr),
        .id_reg_en(id_reg_en), .id_reg_clr(id_reg_clr),
        .exe_reg_en(exe_reg_en), .mem_reg_en(mem_reg_en),
        .hazard(hazard), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Control vector order: pc_en, if_en, if_clr, id_en, id_clr, exe_en, mem_en
    typedef struct {
        logic [6:0] ctl;
        logic       hz;
        logic       err;
        int         stall;
        int         flush;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model state, expressed as rule-level facts
    bit m_waiting, m_dead;
    int m_frozen_run, m_stalls, m_flushes;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic bit reads_reg(input logic [3:0] r);
        return (id_use_src1 && id_src1 == r) || (id_two_src && id_src2 == r);
    endfunction

    function automatic bit model_hazard();
`ifdef PIPE_FWD_EN
        return exe_wb_en && exe_mem_r_en && reads_reg(exe_dest);
`else
        return (exe_wb_en && reads_reg(exe_dest)) || (mem_wb_en && reads_reg(mem_dest));
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called once the current cycle's inputs are applied.
    task automatic issue(input bit push);
        exp_t e;
        bit   hz;
        hz      = model_hazard();
        e.hz    = hz;
        e.err   = m_dead;
        e.stall = m_stalls;
        e.flush = m_flushes;
        e.ctl   = 7'b0000000;
        if (rst) begin
            m_waiting = 0; m_dead = 0; m_frozen_run = 0; m_stalls = 0; m_flushes = 0;
        end else if (m_dead) begin
            e.ctl = 7'b0000000;
        end else if ((m_waiting || mem_req) && !mem_ready) begin
            m_waiting    = 1;
            m_frozen_run = m_frozen_run + 1;
            m_stalls     = sat(m_stalls + 1);
            if (m_frozen_run == TO) begin
                m_dead    = 1;
                m_waiting = 0;
            end
        end else begin
            m_waiting    = 0;
            m_frozen_run = 0;
            if (branch_taken) begin
                e.ctl     = 7'b1111111;
                m_flushes = sat(m_flushes + 1);
            end else if (hz) begin
                e.ctl    = 7'b0001111;
                m_stalls = sat(m_stalls + 1);
            end else begin
                e.ctl = 7'b1101011;
            end
        end
        if (push) sb_q.push_back(e);
    endtask

    task automatic set_idle();
        rst = 0; id_src1 = 4'd1; id_src2 = 4'd2; id_use_src1 = 0; id_two_src = 0;
        exe_dest = 4'd0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 4'd0; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle(); set_idle(); issue(1);
        end
    endtask

    task automatic reset_cycle();
        next_cycle(); set_idle(); rst = 1; issue(1);
    endtask

    task automatic load_use();
        next_cycle(); set_idle();
        exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 4'd3; id_use_src1 = 1;
        issue(1);
    endtask

    // Monitor: the DUT presents a response every cycle; compare it on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ctrl", {pc_en, if_reg_en, if_reg_clr, id_reg_en, id_reg_clr,
                             exe_reg_en, mem_reg_en}, e.ctl);
                chk("hazard", hazard, e.hz);
                chk("mem_err", mem_err, e.err);
                chk("stall_cnt", stall_cnt, e.stall);
                chk("flush_cnt", flush_cnt, e.flush);
            end
        end
    end

    initial begin
        int pcts[3] = '{70, 30, 8};
        set_idle();
        rst = 1;
        // First reset cycle: counters are still unknown, so nothing is expected yet.
        next_cycle(); set_idle(); rst = 1; issue(0);
        reset_cycle();
        idle_cycles(2);

        // Load-use stall then normal flow
        load_use();
        idle_cycles(1);

        // Branch together with a hazard: flush wins
        next_cycle(); set_idle();
        exe_dest = 4'd5; exe_wb_en = 1; id_src2 = 4'd5; id_two_src = 1; branch_taken = 1;
        issue(1);

        // MEM hazard only
        next_cycle(); set_idle();
        mem_dest = 4'd7; mem_wb_en = 1; id_src1 = 4'd7; id_use_src1 = 1;
        issue(1);

        // Five frozen cycles, then release with a branch held in EXE
        reset_cycle();
        for (int i = 0; i < 5; i++) begin
            next_cycle(); set_idle(); mem_req = 1; branch_taken = 1; issue(1);
        end
        next_cycle(); set_idle(); mem_req = 1; mem_ready = 1; branch_taken = 1; issue(1);
        idle_cycles(1);

        // Single-cycle access
        next_cycle(); set_idle(); mem_req = 1; mem_ready = 1; issue(1);

        // Watchdog expiry, sticky error, recovery by reset
        for (int i = 0; i < 12; i++) begin
            next_cycle(); set_idle(); mem_req = 1; mem_ready = (i >= 10); issue(1);
        end
        reset_cycle();
        idle_cycles(2);

        // Reset during the third frozen cycle
        for (int i = 0; i < 2; i++) begin
            next_cycle(); set_idle(); mem_req = 1; issue(1);
        end
        reset_cycle();
        idle_cycles(2);

        // Counter saturation
        for (int i = 0; i < 10; i++) load_use();
        for (int i = 0; i < 10; i++) begin
            next_cycle(); set_idle(); branch_taken = 1; issue(1);
        end
        reset_cycle();

        // Randomized traffic with varying SRAM readiness
        for (int seg = 0; seg < 9; seg++) begin
            for (int i = 0; i < 300; i++) begin
                next_cycle();
                rst          = ($urandom_range(0, 59) == 0);
                id_src1      = 4'($urandom_range(0, 3));
                id_src2      = 4'($urandom_range(0, 3));
                exe_dest     = 4'($urandom_range(0, 3));
                mem_dest     = 4'($urandom_range(0, 3));
                id_use_src1  = ($urandom_range(0, 99) < 70);
                id_two_src   = ($urandom_range(0, 99) < 50);
                exe_wb_en    = ($urandom_range(0, 99) < 60);
                exe_mem_r_en = ($urandom_range(0, 99) < 40);
                mem_wb_en    = ($urandom_range(0, 99) < 60);
                branch_taken = ($urandom_range(0, 99) < 15);
                mem_req      = ($urandom_range(0, 99) < 30);
                mem_ready    = ($urandom_range(0, 99) < pcts[seg % 3]);
                issue(1);
            end
        end

        next_cycle(); set_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
